// File: rtl/bus_seq_pkg.sv
// Shared definitions for the register-transfer bus sequencer:
// source codes, FSM state encoding and the memory-source helper.
package bus_seq_pkg;

  localparam int unsigned SRC_W = 4;
  localparam int unsigned CNT_W = 3;

  localparam logic [SRC_W-1:0] SRC_ZERO = 4'd0;
  localparam logic [SRC_W-1:0] SRC_PC   = 4'd1;
  localparam logic [SRC_W-1:0] SRC_DAR  = 4'd2;
  localparam logic [SRC_W-1:0] SRC_IR   = 4'd4;
  localparam logic [SRC_W-1:0] SRC_AC   = 4'd5;
  localparam logic [SRC_W-1:0] SRC_R    = 4'd6;
  localparam logic [SRC_W-1:0] SRC_R1   = 4'd7;
  localparam logic [SRC_W-1:0] SRC_R2   = 4'd8;
  localparam logic [SRC_W-1:0] SRC_R3   = 4'd9;
  localparam logic [SRC_W-1:0] SRC_R4   = 4'd10;
  localparam logic [SRC_W-1:0] SRC_R5   = 4'd11;
  localparam logic [SRC_W-1:0] SRC_DM   = 4'd12;
  localparam logic [SRC_W-1:0] SRC_IM   = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_MWAIT = 2'd2
  } state_e;

  // Data and instruction memory are the only sources needing wait states.
  function automatic logic is_mem_src(input logic [SRC_W-1:0] code);
    return (code == SRC_DM) || (code == SRC_IM);
  endfunction

endpackage

// File: rtl/bus_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] index
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    winner   = '0;
    index    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand     = (32'(ptr) + i) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        index           = cand_idx;
        winner[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Round-robin register-transfer bus sequencer with memory wait states.
// Optional BUS_SEQ_ABORT_EN cancels a transfer whose requester drops req.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned DST_W    = 12,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   req_src,
  input  logic [DST_W*NREQ-1:0] req_dst,
  output logic [NREQ-1:0]     grant,
  output logic [3:0]          read_en,
  output logic [DST_W-1:0]    write_en,
  output logic                busy
`ifdef BUS_SEQ_ABORT_EN
  ,
  output logic                abort_err
`endif
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [SRC_W-1:0] cur_src;
  logic [DST_W-1:0] cur_dst;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic [SRC_W-1:0] sel_src;
  logic [DST_W-1:0] sel_dst;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (win_onehot),
    .index  (win_idx)
  );

  // Mux the winning requester's source and destination slices.
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_src = req_src[4*i +: 4];
        sel_dst = req_dst[DST_W*i +: DST_W];
      end
    end
  end

  // FSM with registered outputs; busy mirrors the next state being non-idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= IDX_W'(NREQ - 1);
      cur_idx  <= '0;
      cur_src  <= '0;
      cur_dst  <= '0;
      cnt      <= '0;
      grant    <= '0;
      read_en  <= '0;
      write_en <= '0;
      busy     <= 1'b0;
`ifdef BUS_SEQ_ABORT_EN
      abort_err <= 1'b0;
`endif
    end else begin
      grant    <= '0;
      read_en  <= '0;
      write_en <= '0;
      case (state)
        ST_IDLE: begin
          if (|win_onehot) begin
            cur_idx <= win_idx;
            cur_src <= sel_src;
            cur_dst <= sel_dst;
            ptr     <= win_idx;
            state   <= ST_XFER;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end

        ST_XFER: begin
`ifdef BUS_SEQ_ABORT_EN
          if (!req[cur_idx]) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            abort_err <= 1'b1;
          end else begin
`else
          begin
`endif
            read_en <= cur_src;
            if (is_mem_src(cur_src) && (MEM_WAIT != 0)) begin
              cnt   <= CNT_W'(MEM_WAIT);
              state <= ST_MWAIT;
              busy  <= 1'b1;
            end else begin
              write_en <= cur_dst;
              grant    <= NREQ'(1) << cur_idx;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end
          end
        end

        ST_MWAIT: begin
`ifdef BUS_SEQ_ABORT_EN
          if (!req[cur_idx]) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            abort_err <= 1'b1;
          end else begin
`else
          begin
`endif
            read_en <= cur_src;
            cnt     <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              write_en <= cur_dst;
              grant    <= NREQ'(1) << cur_idx;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              busy     <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
